// File: rtl/vfifo_frame_reader_pkg.sv
// Shared constants, state encodings and pointer helper for the frame reader.
// Imported by vfifo_frame_reader and vfifo_frame_obuf.
package vfifo_frame_reader_pkg;

   // Reader parse state: waiting for a header, or streaming body words.
   typedef enum logic {
      HDR  = 1'b0,
      BODY = 1'b1
   } state_t;

   // Output buffer depth and the widths needed to count it.
   localparam int unsigned OBUF_DEPTH = 3;
   localparam int unsigned OCC_WIDTH  = 2;
   localparam int unsigned FILL_WIDTH = OCC_WIDTH + 1;

   // Ring-pointer increment that wraps at OBUF_DEPTH.
   function automatic logic [OCC_WIDTH-1:0] ptr_inc(input logic [OCC_WIDTH-1:0] p);
      return (p == OCC_WIDTH'(OBUF_DEPTH - 1)) ? '0 : p + OCC_WIDTH'(1);
   endfunction

endpackage

// File: rtl/vfifo_frame_obuf.sv
// 3-entry output buffer holding stream words with their sop/eop marks.
// Ports:
//   clk, rst             clock, async active-low reset
//   push, push_data,
//   push_sop, push_eop   write one entry (caller guarantees space)
//   pop                  remove head entry; ignored when empty
//   occ                  number of entries held
//   head_data, head_sop,
//   head_eop             head entry, forced to zero when empty
module vfifo_frame_obuf
   import vfifo_frame_reader_pkg::*;
#(
   parameter int unsigned data_width = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [data_width-1:0] push_data,
   input  logic                  push_sop,
   input  logic                  push_eop,
   input  logic                  pop,
   output logic [OCC_WIDTH-1:0]  occ,
   output logic [data_width-1:0] head_data,
   output logic                  head_sop,
   output logic                  head_eop
);

   logic [data_width-1:0] data_mem [OBUF_DEPTH];
   logic [OBUF_DEPTH-1:0] sop_mem;
   logic [OBUF_DEPTH-1:0] eop_mem;
   logic [OCC_WIDTH-1:0]  wr_ptr;
   logic [OCC_WIDTH-1:0]  rd_ptr;
   logic                  not_empty;
   logic                  do_pop;

   assign not_empty = (occ != '0);
   assign do_pop    = pop && not_empty;

   // Payload storage; contents are only observed through the gated head.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= push_data;
         sop_mem[wr_ptr]  <= push_sop;
         eop_mem[wr_ptr]  <= push_eop;
      end
   end

   // Pointers and occupancy; push and pop together leave occ unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, do_pop})
            2'b10:   occ <= occ + OCC_WIDTH'(1);
            2'b01:   occ <= occ - OCC_WIDTH'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Head is zero whenever nothing is buffered, so reset clears it at once.
   assign head_data = not_empty ? data_mem[rd_ptr] : '0;
   assign head_sop  = not_empty && sop_mem[rd_ptr];
   assign head_eop  = not_empty && eop_mem[rd_ptr];

endmodule

// File: rtl/vfifo_frame_reader.sv
// Drains a FIFO read port carrying header-delimited frames (one header word
// holding length L, then L body words) and presents the body as a
// valid/ready stream with sop/eop marks.
// Ports:
//   clk, rst             clock, async active-low reset
//   fifo_q, fifo_empty   FIFO read data (valid one clk after fifo_rd), empty
//   fifo_rd              FIFO read strobe
//   m_data, m_valid,
//   m_ready, m_sop,
//   m_eop                output stream
//   frame_len            length latched from the current frame's header
//   busy                 frame in progress, words buffered or read in flight
//   err_zero_len         one-clk pulse when a zero-length header is dropped
module vfifo_frame_reader
   import vfifo_frame_reader_pkg::*;
#(
   parameter int unsigned data_width = 18,
   parameter int unsigned len_width  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [data_width-1:0] fifo_q,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   output logic [data_width-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sop,
   output logic                  m_eop,
   output logic [len_width-1:0]  frame_len,
   output logic                  busy,
   output logic                  err_zero_len
);

   state_t                state;
   state_t                state_nxt;
   logic                  inflight;
   logic [len_width-1:0]  remaining;
   logic [len_width-1:0]  remaining_nxt;
   logic [len_width-1:0]  frame_len_nxt;
   logic [len_width-1:0]  word_len;
   logic                  err_nxt;
   logic                  push;
   logic                  push_sop;
   logic                  push_eop;
   logic [OCC_WIDTH-1:0]  occ;
   logic [FILL_WIDTH-1:0] fill;

   // Reads are paced by buffer space already claimed, never by m_ready, so
   // a returned word always has a slot even if nothing drains this cycle.
   assign fill    = FILL_WIDTH'(occ) + FILL_WIDTH'(inflight);
   assign fifo_rd = rst && !fifo_empty && (fill < FILL_WIDTH'(OBUF_DEPTH));

   assign word_len = fifo_q[len_width-1:0];

   // Read-return tracker: fifo_q is meaningful the clk after a read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd;
      end
   end

   // State and frame bookkeeping registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= HDR;
         remaining    <= '0;
         frame_len    <= '0;
         err_zero_len <= 1'b0;
      end else begin
         state        <= state_nxt;
         remaining    <= remaining_nxt;
         frame_len    <= frame_len_nxt;
         err_zero_len <= err_nxt;
      end
   end

   // Header parse / body forwarding.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      frame_len_nxt = frame_len;
      err_nxt       = 1'b0;
      push          = 1'b0;
      push_sop      = 1'b0;
      push_eop      = 1'b0;
      if (inflight) begin
         case (state)
            HDR: begin
               if (word_len == '0) begin
                  err_nxt = 1'b1;
               end else begin
                  frame_len_nxt = word_len;
                  remaining_nxt = word_len;
                  state_nxt     = BODY;
               end
            end
            BODY: begin
               push          = 1'b1;
               // remaining still equals the header length only on word one
               push_sop      = (remaining == frame_len);
               push_eop      = (remaining == len_width'(1));
               remaining_nxt = remaining - len_width'(1);
               if (push_eop) begin
                  state_nxt = HDR;
               end
            end
            default: state_nxt = HDR;
         endcase
      end
   end

   vfifo_frame_obuf #(
      .data_width (data_width)
   ) u_obuf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (fifo_q),
      .push_sop  (push_sop),
      .push_eop  (push_eop),
      .pop       (m_ready),
      .occ       (occ),
      .head_data (m_data),
      .head_sop  (m_sop),
      .head_eop  (m_eop)
   );

   assign m_valid = (occ != '0);
   assign busy    = (state == BODY) || (occ != '0) || inflight;

endmodule

// File: tb/tb_vfifo_frame_reader.sv
`timescale 1ns/1ps
module tb_vfifo_frame_reader;
   localparam int unsigned DW = 18;
   localparam int unsigned LW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] fifo_q = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          m_sop;
   logic          m_eop;
   logic [LW-1:0] frame_len;
   logic          busy;
   logic          err_zero_len;

   always #5 clk = ~clk;

   vfifo_frame_reader #(.data_width(DW), .len_width(LW)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_q       (fifo_q),
      .fifo_empty   (fifo_empty),
      .fifo_rd      (fifo_rd),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_sop        (m_sop),
      .m_eop        (m_eop),
      .frame_len    (frame_len),
      .busy         (busy),
      .err_zero_len (err_zero_len)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] fifo_mem[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int sop_cnt = 0;
   int eop_cnt = 0;
   int err_cnt = 0;
   int rd_viol = 0;
   int first_rd_cyc = 0;
   bit first_rd_seen = 1'b0;
   int sop_cyc = 0;
   int eop_cyc = 0;
   bit rand_en = 1'b0;
   logic ready_force = 1'b0;
   bit rd_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fifo_push(input logic [DW-1:0] w);
      fifo_mem.push_back(w);
   endtask

   task automatic exp_push(input logic [DW-1:0] d, input logic s, input logic e);
      exp_t x;
      x.data = d; x.sop = s; x.eop = e;
      exp_q.push_back(x);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (!(exp_q.size() == 0 && fifo_mem.size() == 0 && !busy) && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= budget) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_q.size());
      end
   endtask

   task automatic wait_pop(input string name, input int target, input int budget);
      int n = 0;
      while (pop_cnt < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= budget) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got %0d pops expected %0d", name, pop_cnt, target);
      end
   endtask

   // FIFO model and input driver: inputs change 1 ns after the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         rd_seen = fifo_rd && rst;
         @(posedge clk); #1;
         if (rd_seen && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
         fifo_empty = (fifo_mem.size() == 0) || (rand_en && $urandom_range(0, 3) == 0);
         m_ready    = rand_en ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   // Monitor: pops the scoreboard on every accepted stream word.
   always @(negedge clk) begin : mon
      exp_t e;
      cyc++;
      if (rst) begin
         if (fifo_rd && fifo_empty) rd_viol++;
         if (err_zero_len) err_cnt++;
         if (fifo_rd && !first_rd_seen) begin
            first_rd_seen = 1'b1;
            first_rd_cyc  = cyc;
         end
         if (m_valid && m_ready) begin
            pop_cnt++;
            if (m_sop) begin sop_cnt++; sop_cyc = cyc; end
            if (m_eop) begin eop_cnt++; eop_cyc = cyc; end
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_word: got data=0x%0h expected no word", m_data);
            end else begin
               e = exp_q.pop_front();
               if ({m_data, m_sop, m_eop} !== {e.data, e.sop, e.eop}) begin
                  miscompares++;
                  $display("FAIL stream_word: got data=0x%0h sop=%0b eop=%0b expected data=0x%0h sop=%0b eop=%0b",
                           m_data, m_sop, m_eop, e.data, e.sop, e.eop);
               end
            end
         end
      end
   end

   initial begin
      int base;
      int n;
      int nz;
      int len;
      logic [DW-1:0] held;
      logic [DW-1:0] w;

      // Reset state
      #12;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_sop", m_sop, 0);
      check("rst_m_eop", m_eop, 0);
      check("rst_fifo_rd", fifo_rd, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_len", frame_len, 0);
      check("rst_err", err_zero_len, 0);
      @(posedge clk); #2;
      rst = 1'b1;

      // Three-word frame at full rate
      ready_force = 1'b1;
      first_rd_seen = 1'b0;
      fifo_push(18'h003); fifo_push(18'h0A); fifo_push(18'h0B); fifo_push(18'h0C);
      exp_push(18'h0A, 1, 0); exp_push(18'h0B, 0, 0); exp_push(18'h0C, 0, 1);
      wait_idle("t1", 200);
      check("t1_frame_len", frame_len, 3);
      check("t1_sop_cycle", sop_cyc, first_rd_cyc + 3);
      check("t1_eop_cycle", eop_cyc, first_rd_cyc + 5);

      // Single-word frame, then idle
      first_rd_seen = 1'b0;
      fifo_push(18'h001); fifo_push(18'h005);
      exp_push(18'h005, 1, 1);
      n = 0;
      while (!(first_rd_seen && cyc >= first_rd_cyc + 4) && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check("t2_sop_cycle", sop_cyc, first_rd_cyc + 3);
      check("t2_eop_cycle", eop_cyc, first_rd_cyc + 3);
      check("t2_busy_after", busy, 0);
      wait_idle("t2", 200);
      check("t2_frame_len", frame_len, 1);

      // Zero-length header dropped
      err_cnt = 0;
      fifo_push(18'h000); fifo_push(18'h002); fifo_push(18'h007); fifo_push(18'h008);
      exp_push(18'h007, 1, 0); exp_push(18'h008, 0, 1);
      wait_idle("t3", 200);
      check("t3_err_pulses", err_cnt, 1);
      check("t3_frame_len", frame_len, 2);

      // Backpressure mid-frame
      base = pop_cnt;
      fifo_push(18'h006);
      for (int i = 0; i < 6; i++) begin
         fifo_push(18'h010 + DW'(i));
         exp_push(18'h010 + DW'(i), i == 0, i == 5);
      end
      wait_pop("t4_first", base + 1, 200);
      ready_force = 1'b0;
      held = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("t4_stall_valid", m_valid, 1);
         check("t4_stall_data", m_data, 18'h011);
         if (i == 0) held = m_data;
         else check("t4_stall_hold", m_data, held);
      end
      check("t4_stall_fifo_rd", fifo_rd, 0);
      check("t4_stall_occ", dut.u_obuf.occ, 3);
      ready_force = 1'b1;
      wait_idle("t4", 200);
      check("t4_word_count", pop_cnt, base + 6);

      // Reset mid-frame
      base = pop_cnt;
      fifo_push(18'h004);
      for (int i = 0; i < 4; i++) begin
         fifo_push(18'h031 + DW'(i));
         exp_push(18'h031 + DW'(i), i == 0, i == 3);
      end
      wait_pop("t5_two", base + 2, 200);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("t5_m_valid", m_valid, 0);
      check("t5_m_data", m_data, 0);
      check("t5_m_sop", m_sop, 0);
      check("t5_m_eop", m_eop, 0);
      check("t5_busy", busy, 0);
      check("t5_frame_len", frame_len, 0);
      check("t5_fifo_rd", fifo_rd, 0);
      exp_q.delete();
      fifo_mem.delete();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      fifo_push(18'h002); fifo_push(18'h041); fifo_push(18'h042);
      exp_push(18'h041, 1, 0); exp_push(18'h042, 0, 1);
      wait_idle("t5", 200);
      check("t5_frame_len_after", frame_len, 2);

      // Random traffic
      sop_cnt = 0;
      eop_cnt = 0;
      nz = 0;
      rand_en = 1'b1;
      for (int f = 0; f < 1000; f++) begin
         len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
         w = DW'($urandom);
         w[LW-1:0] = LW'(len);
         fifo_push(w);
         if (len > 0) nz++;
         for (int i = 0; i < len; i++) begin
            w = DW'($urandom);
            fifo_push(w);
            exp_push(w, i == 0, i == len - 1);
         end
      end
      wait_idle("t6", 80000);
      rand_en = 1'b0;
      check("t6_sop_count", sop_cnt, nz);
      check("t6_eop_count", eop_cnt, nz);
      check("fifo_rd_while_empty", rd_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
